// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a word-addressed register-array SRAM, with independent read and write channel FSMs.
// Optional macro AXI_SRAM_RAND_DELAY_EN adds LFSR-driven read latency and wready stalls.
module axi_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(RD_LAT + 16);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) && ((off >> 2) < DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return IDX_W'(off >> 2);
  endfunction

  // Extra delay sources: random under the stress macro, zero otherwise
  logic [3:0] rd_extra;
  logic [1:0] w_stall;
`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign rd_extra = lfsr[3:0];
  assign w_stall  = lfsr[1:0];
`else
  assign rd_extra = 4'd0;
  assign w_stall  = 2'd0;
`endif

  logic [CNT_W-1:0] rd_reload;
  assign rd_reload = CNT_W'(RD_LAT - 1) + CNT_W'(rd_extra);

  // Read channel
  rd_state_t        rstate, rstate_d;
  logic [31:0]      raddr, raddr_d, rdata, rdata_d;
  logic [CNT_W-1:0] rcnt, rcnt_d;
  logic [7:0]       rrem, rrem_d;
  logic [3:0]       rid, rid_d;
  logic [1:0]       rresp, rresp_d;
  logic             arready, arready_d, rvalid, rvalid_d, rlast, rlast_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstate  <= R_IDLE;
      raddr   <= '0;
      rcnt    <= '0;
      rrem    <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
    end else begin
      rstate  <= rstate_d;
      raddr   <= raddr_d;
      rcnt    <= rcnt_d;
      rrem    <= rrem_d;
      rid     <= rid_d;
      rdata   <= rdata_d;
      rresp   <= rresp_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
    end
  end

  always_comb begin
    rstate_d  = rstate;
    raddr_d   = raddr;
    rcnt_d    = rcnt;
    rrem_d    = rrem;
    rid_d     = rid;
    rdata_d   = rdata;
    rresp_d   = rresp;
    arready_d = arready;
    rvalid_d  = rvalid;
    rlast_d   = rlast;
    unique case (rstate)
      R_IDLE: begin
        if (io_slave_arvalid && arready) begin
          rstate_d  = R_WAIT;
          raddr_d   = io_slave_araddr;
          rid_d     = io_slave_arid;
          rrem_d    = io_slave_arlen;
          rcnt_d    = rd_reload;
          arready_d = 1'b0;
        end
      end
      R_WAIT: begin
        if (rcnt == '0) begin
          // Memory is sampled here so a same-edge write is not yet visible
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rlast_d  = (rrem == 8'd0);
          if (in_range(raddr)) begin
            rdata_d = mem[word_idx(raddr)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = 32'd0;
            rresp_d = RESP_DECERR;
          end
        end else begin
          rcnt_d = rcnt - CNT_W'(1);
        end
      end
      R_DATA: begin
        if (io_slave_rready) begin
          rvalid_d = 1'b0;
          if (rlast) begin
            rstate_d  = R_IDLE;
            arready_d = 1'b1;
            rlast_d   = 1'b0;
          end else begin
            rstate_d = R_WAIT;
            raddr_d  = raddr + 32'd4;
            rrem_d   = rrem - 8'd1;
            rcnt_d   = rd_reload;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write channel
  wr_state_t   wstate, wstate_d;
  logic [31:0] waddr, waddr_d;
  logic [3:0]  bid, bid_d;
  logic [1:0]  bresp, bresp_d, wstall, wstall_d;
  logic        werr, werr_d, awready, awready_d, wready, wready_d, bvalid, bvalid_d;
  logic        mem_we_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wstate  <= W_IDLE;
      waddr   <= '0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      wstall  <= '0;
      werr    <= 1'b0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
    end else begin
      wstate  <= wstate_d;
      waddr   <= waddr_d;
      bid     <= bid_d;
      bresp   <= bresp_d;
      wstall  <= wstall_d;
      werr    <= werr_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
    end
  end

  always_comb begin
    wstate_d  = wstate;
    waddr_d   = waddr;
    bid_d     = bid;
    bresp_d   = bresp;
    wstall_d  = wstall;
    werr_d    = werr;
    awready_d = awready;
    wready_d  = wready;
    bvalid_d  = bvalid;
    mem_we_c  = 1'b0;
    unique case (wstate)
      W_IDLE: begin
        if (io_slave_awvalid && awready) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          waddr_d   = io_slave_awaddr;
          bid_d     = io_slave_awid;
          werr_d    = 1'b0;
          wstall_d  = w_stall;
          wready_d  = (w_stall == 2'd0);
        end
      end
      W_DATA: begin
        if (io_slave_wvalid && wready) begin
          mem_we_c = in_range(waddr);
          werr_d   = werr | ~in_range(waddr);
          waddr_d  = waddr + 32'd4;
          if (io_slave_wlast) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr || !in_range(waddr)) ? RESP_DECERR : RESP_OKAY;
          end else begin
            wstall_d = w_stall;
            wready_d = (w_stall == 2'd0);
          end
        end else if (!wready) begin
          if (wstall <= 2'd1) begin
            wstall_d = 2'd0;
            wready_d = 1'b1;
          end else begin
            wstall_d = wstall - 2'd1;
          end
        end
      end
      W_RESP: begin
        if (io_slave_bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Byte-masked array write; storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave_wstrb[i]) mem[word_idx(waddr)][8*i +: 8] <= io_slave_wdata[8*i +: 8];
      end
    end
  end

  // Burst length on AW is informational only; wlast terminates the burst
  logic unused_awlen;
  assign unused_awlen = ^io_slave_awlen;

  assign io_slave_awready = awready;
  assign io_slave_wready  = wready;
  assign io_slave_bvalid  = bvalid;
  assign io_slave_bresp   = bresp;
  assign io_slave_bid     = bid;
  assign io_slave_arready = arready;
  assign io_slave_rvalid  = rvalid;
  assign io_slave_rresp   = rresp;
  assign io_slave_rdata   = rdata;
  assign io_slave_rlast   = rlast;
  assign io_slave_rid     = rid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (default build): strobes, bursts, DECERR, boundaries, collisions, reset.
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awready, awvalid = 1'b0, wready, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, bvalid;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  awid = '0, wstrb = '0, bid, arid = '0, rid;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [1:0]  bresp, rresp;
  logic        arready, arvalid = 1'b0, rready = 1'b0, rvalid, rlast;

  axi_sram_slave dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
    .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
    .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
    .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [31:0] rd_hold [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  int          rd_lat;

  task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    araddr = a; arid = id; arlen = len; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clock); n++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(negedge clock);
    arvalid = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clock); n++; end
    check("aw_accept", 32'(awready), 32'd1);
    @(negedge clock);
    awvalid = 1'b0;
  endtask

  // Collects every beat; optional two-cycle rready stall records what rdata showed while held
  task automatic rd_burst(input logic [31:0] a, input logic [3:0] id, input int len, input bit stall);
    ar_send(a, id, 8'(len));
    for (int k = 0; k <= len; k++) begin
      int n = 0;
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      if (k == 0) rd_lat = n;
      check("r_valid", 32'(rvalid), 32'd1);
      if (stall) begin
        repeat (2) @(negedge clock);
        rd_hold[k] = rvalid ? rdata : 32'hBAD0_BAD0;
      end
      rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast; rd_id[k] = rid;
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
    end
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [3:0] id, input int len);
    int n;
    aw_send(a, id, 8'(len));
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1; wdata = wr_data[k]; wstrb = wr_strb[k]; wlast = (k == len);
      n = 0;
      while (!wready && n < 50) begin @(negedge clock); n++; end
      check("w_ready", 32'(wready), 32'd1);
      @(negedge clock);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clock); n++; end
    check("b_valid", 32'(bvalid), 32'd1);
    b_resp = bresp; b_id = bid;
    @(negedge clock);
    bready = 1'b0;
  endtask

  task automatic wr_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_data[0] = d; wr_strb[0] = s;
    wr_burst(a, 4'h1, 0);
  endtask

  logic [31:0] exp_w [4];
  int spurious;

  initial begin
    exp_w[0] = 32'hCAFE_0000; exp_w[1] = 32'h1234_5678;
    exp_w[2] = 32'h0BAD_F00D; exp_w[3] = 32'hFEED_FACE;

    repeat (3) @(negedge clock);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    reset = 1'b1;
    @(negedge clock);

    // W before AW must not be consumed
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wlast = 1'b1;
    repeat (3) @(negedge clock);
    check("w_early_wready", 32'(wready), 32'd0);
    wvalid = 1'b0; wlast = 1'b0;

    for (int k = 0; k < 4; k++) begin wr_data[k] = exp_w[k]; wr_strb[k] = 4'hF; end
    wr_burst(32'h8000_0000, 4'h7, 3);
    check("wb_bresp", 32'(b_resp), 32'd0);
    check("wb_bid",   32'(b_id),   32'h7);

    wr_word(32'h8000_0010, 32'h1122_3344, 4'hF);
    wr_word(32'h8000_0010, 32'hDEAD_BEEF, 4'b0101);
    check("strb_bresp", 32'(b_resp), 32'd0);
    rd_burst(32'h8000_0010, 4'h2, 0, 1'b0);
    check("strb_data",  rd_data[0], 32'h11AD_33EF);
    check("strb_rresp", 32'(rd_resp[0]), 32'd0);
    check("strb_rlast", 32'(rd_last[0]), 32'd1);
    check("rd_latency", 32'(rd_lat), 32'd1);

    rd_burst(32'h8000_0000, 4'h3, 3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_data%0d", k), rd_data[k], exp_w[k]);
      check($sformatf("burst_hold%0d", k), rd_hold[k], exp_w[k]);
      check($sformatf("burst_rid%0d", k),  32'(rd_id[k]), 32'h3);
      check($sformatf("burst_last%0d", k), 32'(rd_last[k]), (k == 3) ? 32'd1 : 32'd0);
    end
    check("burst_latency", 32'(rd_lat), 32'd1);

    rd_burst(32'h0000_1000, 4'h5, 0, 1'b0);
    check("dec_rresp", 32'(rd_resp[0]), 32'd3);
    check("dec_rdata", rd_data[0], 32'd0);
    check("dec_rid",   32'(rd_id[0]), 32'h5);
    wr_word(32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
    check("dec_bresp", 32'(b_resp), 32'd3);
    rd_burst(32'h8000_0000, 4'h0, 0, 1'b0);
    check("dec_mem_keep", rd_data[0], exp_w[0]);

    // Burst straddling the top of the window: first beat lands, second errors
    wr_data[0] = 32'h5A5A_5A5A; wr_strb[0] = 4'hF;
    wr_data[1] = 32'h7777_7777; wr_strb[1] = 4'hF;
    wr_burst(32'h8000_3FFC, 4'h9, 1);
    check("top_bresp", 32'(b_resp), 32'd3);
    check("top_bid",   32'(b_id),   32'h9);
    rd_burst(32'h8000_3FFC, 4'h4, 1, 1'b0);
    check("top_rdata0", rd_data[0], 32'h5A5A_5A5A);
    check("top_rresp0", 32'(rd_resp[0]), 32'd0);
    check("top_rresp1", 32'(rd_resp[1]), 32'd3);
    check("top_rdata1", rd_data[1], 32'd0);
    rd_burst(32'h7FFF_FFFC, 4'h4, 0, 1'b0);
    check("below_rresp", 32'(rd_resp[0]), 32'd3);

    // Same-cycle AR and AW on one word: read sees the old value
    wr_word(32'h8000_0020, 32'h0, 4'hF);
    araddr = 32'h8000_0020; arid = 4'hA; arlen = 8'd0; arvalid = 1'b1;
    awaddr = 32'h8000_0020; awid = 4'hB; awlen = 8'd0; awvalid = 1'b1;
    wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wlast = 1'b1;
    @(negedge clock);
    check("coll_arready", 32'(arready), 32'd0);
    check("coll_awready", 32'(awready), 32'd0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge clock);
    wvalid = 1'b0; wlast = 1'b0;
    check("coll_rvalid", 32'(rvalid), 32'd1);
    check("coll_rdata",  rdata, 32'h0);
    check("coll_bvalid", 32'(bvalid), 32'd1);
    check("coll_bid",    32'(bid), 32'hB);
    rready = 1'b1; bready = 1'b1;
    @(negedge clock);
    rready = 1'b0; bready = 1'b0;
    rd_burst(32'h8000_0020, 4'h1, 0, 1'b0);
    check("coll_next", rd_data[0], 32'h5);

    // Reset during a read burst
    ar_send(32'h8000_0000, 4'h6, 8'd3);
    @(negedge clock);
    check("mid_rvalid_b0", 32'(rvalid), 32'd1);
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    @(negedge clock);
    check("mid_rvalid_b1", 32'(rvalid), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_rvalid",  32'(rvalid),  32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    check("mid_rst_awready", 32'(awready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    rready = 1'b1;
    spurious = 0;
    repeat (6) begin
      @(negedge clock);
      if (rvalid) spurious++;
    end
    rready = 1'b0;
    check("mid_no_spurious", 32'(spurious), 32'd0);
    rd_burst(32'h8000_0010, 4'h2, 0, 1'b0);
    check("mid_mem_keep", rd_data[0], 32'h11AD_33EF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
